// File: rtl/fixed_exp_sched.sv
// Round-robin scheduler sharing one iterative e^x engine (Q3.7 in, Q5.5 out)
// among NREQ requesters, with bypass for x == 0 / saturating x and an engine timeout.
module fixed_exp_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter logic [9:0]  SAT_X   = 10'd443,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*10-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [9:0]           rsp_r,
    output logic                 rsp_sat,
    output logic                 rsp_err,
    output logic                 eng_start,
    output logic [9:0]           eng_x,
    output logic                 eng_abort,
    input  logic                 eng_done,
    input  logic [9:0]           eng_r
);

    localparam int unsigned XW      = 10;
    localparam int unsigned CW      = 8;
    localparam int unsigned ONE_Q55 = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   cnt;
    logic [XW-1:0]   x_q;

    logic            sel_found_c;
    logic [IDW-1:0]  sel_idx_c;
    logic [XW-1:0]   sel_x_c;

    // First valid requester at or after ptr; scanned from the far end so the nearest wins.
    always_comb begin
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        sel_x_c     = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            int j;
            j = (int'(ptr) + int'(NREQ) - 1 - i) % int'(NREQ);
            if (req_valid[j]) begin
                sel_found_c = 1'b1;
                sel_idx_c   = IDW'(j);
                sel_x_c     = req_x[j*int'(XW) +: XW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            x_q       <= '0;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_r     <= '0;
            rsp_sat   <= 1'b0;
            rsp_err   <= 1'b0;
            eng_start <= 1'b0;
            eng_x     <= '0;
            eng_abort <= 1'b0;
        end else begin
            req_ready <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) state <= S_GRANT;
                end
                S_GRANT: begin
                    if (sel_found_c) begin
                        req_ready <= NREQ'(1) << sel_idx_c;
                        rsp_id    <= sel_idx_c;
                        x_q       <= sel_x_c;
                        ptr       <= (sel_idx_c == IDW'(NREQ - 1)) ? '0 : sel_idx_c + IDW'(1);
                        if (sel_x_c == '0) begin
                            rsp_r <= XW'(ONE_Q55);
                            state <= S_RESP;
                        end else if (sel_x_c > SAT_X) begin
                            rsp_r   <= '1;
                            rsp_sat <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    eng_start <= 1'b1;
                    eng_x     <= x_q;
                    cnt       <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // A done arriving on the timeout cycle still counts as success.
                    if (eng_done) begin
                        rsp_r     <= eng_r;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt + CW'(1) == CW'(TIMEOUT)) begin
                        eng_abort <= 1'b1;
                        rsp_r     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Bypass results enter with rsp_valid low and raise it one cycle after the grant.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_sat   <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= (|req_valid) ? S_GRANT : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_exp_sched.sv
// Self-checking bench for fixed_exp_sched: directed scenarios followed by randomized
// batches checked against a rule-level model of arbitration, bypass and engine results.
module tb_fixed_exp_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;
    localparam logic [9:0] SAT_X = 10'd443;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*10-1:0] req_x;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [9:0]        rsp_r;
    logic              rsp_sat;
    logic              rsp_err;
    logic              eng_start;
    logic [9:0]        eng_x;
    logic              eng_abort;
    logic              eng_done;
    logic [9:0]        eng_r;

    int n_chk  = 0;
    int n_fail = 0;
    int n_start = 0;
    int ptr_m  = 0;

    fixed_exp_sched #(
        .NREQ(NREQ), .IDW(IDW), .SAT_X(SAT_X), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_sat(rsp_sat), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_x(eng_x), .eng_abort(eng_abort),
        .eng_done(eng_done), .eng_r(eng_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // e^x for unsigned Q3.7 x, rounded to unsigned Q5.5.
    function automatic logic [9:0] exp_q55(input logic [9:0] x);
        real v;
        v = $exp(real'(x) / 128.0) * 32.0 + 0.5;
        if (v > 1023.0) v = 1023.0;
        return 10'($rtoi(v));
    endfunction

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [9:0] rand_x();
        case ($urandom_range(0, 5))
            0:       return 10'd0;
            1:       return 10'($urandom_range(444, 1023));
            2:       return SAT_X;
            default: return 10'($urandom_range(1, 443));
        endcase
    endfunction

    always @(posedge clk) if (eng_start) n_start++;

    always @(negedge clk)
        if (req_ready != '0) chk("req_ready_onehot", 64'($onehot(req_ready)), 64'(1));

    // One full transaction for requester id; d < 0 means the engine never answers.
    task automatic serve(input int id, input logic [9:0] x, input int d, input logic [9:0] ev,
                         input int bp, input bit drop);
        int k;
        int s0;
        logic [9:0] exp_r;
        logic sat;
        logic err;
        k = 0;
        while (req_ready == '0 && k < 12) begin @(negedge clk); k++; end
        chk("grant_id", 64'(req_ready), 64'(1) << id);
        if (drop) req_valid[id] = 1'b0;
        s0 = n_start;
        sat = 1'b0;
        err = 1'b0;
        if (x == 10'd0 || x > SAT_X) begin
            exp_r = (x == 10'd0) ? 10'd32 : 10'h3FF;
            sat = (x != 10'd0);
            @(negedge clk);
            chk("bypass_latency", {rsp_valid, req_ready}, {1'b1, 4'b0});
        end else begin
            @(negedge clk);
            chk("eng_start", {eng_start, req_ready}, {1'b1, 4'b0});
            chk("eng_x", 64'(eng_x), 64'(x));
            if (d >= 0) begin
                repeat (d) @(negedge clk);
                eng_done = 1'b1;
                eng_r = ev;
                @(negedge clk);
                eng_done = 1'b0;
                eng_r = 10'($urandom);
                exp_r = ev;
                chk("eng_rsp_latency", {rsp_valid, eng_abort}, 2'b10);
            end else begin
                k = 0;
                while (!eng_abort && k < 40) begin @(negedge clk); k++; end
                chk("abort_latency", 64'(k), 64'(TIMEOUT));
                chk("timeout_rsp_valid", 64'(rsp_valid), 64'(1));
                exp_r = 10'd0;
                err = 1'b1;
            end
        end
        chk("rsp_fields", {rsp_id, rsp_r, rsp_sat, rsp_err}, {2'(id), exp_r, sat, err});
        repeat (bp) begin
            @(negedge clk);
            chk("rsp_hold", {rsp_valid, rsp_id, rsp_r, rsp_sat, rsp_err, req_ready, eng_abort},
                {1'b1, 2'(id), exp_r, sat, err, 4'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_accept", {rsp_valid, rsp_sat, rsp_err}, 3'b0);
        chk("start_count", 64'(n_start - s0), (x == 10'd0 || x > SAT_X) ? 64'(0) : 64'(1));
        ptr_m = (id + 1) % NREQ;
    endtask

    initial begin
        int k;
        rst = 1'b0;
        req_valid = '0;
        req_x = '0;
        rsp_ready = 1'b0;
        eng_done = 1'b0;
        eng_r = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {req_ready, rsp_valid, rsp_id, rsp_r, rsp_sat, rsp_err, eng_start, eng_x, eng_abort}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single engine request, engine answers 10 cycles after start.
        req_x[10 +: 10] = 10'd128;
        req_valid = 4'b0010;
        serve(1, 10'd128, 10, 10'd87, 0, 1);

        // Bypass: x == 0 then saturating x.
        req_x[20 +: 10] = 10'd0;
        req_valid = 4'b0100;
        serve(2, 10'd0, 0, 10'd0, 0, 1);
        req_x[30 +: 10] = 10'd500;
        req_valid = 4'b1000;
        serve(3, 10'd500, 0, 10'd0, 0, 1);

        // Engine hang -> timeout and abort.
        req_x[0 +: 10] = 10'd200;
        req_valid = 4'b0001;
        serve(0, 10'd200, -1, 10'd0, 2, 1);

        // Long backpressure with requester 0 waiting behind.
        req_x[0 +: 10] = 10'd0;
        req_x[10 +: 10] = 10'd0;
        req_valid = 4'b0011;
        serve(1, 10'd0, 0, 10'd0, 20, 1);
        serve(0, 10'd0, 0, 10'd0, 0, 1);

        // Boundaries: largest unsaturated x with done on the timeout cycle, first saturating x.
        req_x[10 +: 10] = SAT_X;
        req_valid = 4'b0010;
        serve(1, SAT_X, TIMEOUT - 1, exp_q55(SAT_X), 1, 1);
        req_x[20 +: 10] = 10'd444;
        req_valid = 4'b0100;
        serve(2, 10'd444, 0, 10'd0, 0, 1);

        // Reset in WAIT, late done must be ignored.
        req_x[30 +: 10] = 10'd300;
        req_valid = 4'b1000;
        k = 0;
        while (req_ready == '0 && k < 12) begin @(negedge clk); k++; end
        chk("rst_pre_grant", 64'(req_ready), 64'(4'b1000));
        req_valid = '0;
        @(negedge clk);
        chk("rst_pre_start", 64'(eng_start), 64'(1));
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("reset_in_wait",
            {req_ready, rsp_valid, rsp_id, rsp_r, rsp_sat, rsp_err, eng_start, eng_x, eng_abort}, 0);
        eng_done = 1'b1;
        eng_r = 10'd77;
        @(negedge clk);
        eng_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_done_ignored", {rsp_valid, eng_start, eng_abort, req_ready}, 0);
        end
        ptr_m = 0;

        // All requesters valid continuously: order 0,1,2,3,0 from a reset pointer.
        req_x = '0;
        req_valid = 4'hF;
        serve(0, 10'd0, 0, 10'd0, 0, 0);
        serve(1, 10'd0, 0, 10'd0, 0, 0);
        serve(2, 10'd0, 0, 10'd0, 0, 0);
        serve(3, 10'd0, 0, 10'd0, 0, 0);
        serve(0, 10'd0, 0, 10'd0, 0, 0);
        req_valid = '0;
        repeat (4) begin
            @(negedge clk);
            chk("no_grant_when_dropped", {req_ready, rsp_valid}, 0);
        end

        // Randomized batches against the arbitration/result model.
        for (int b = 0; b < 30; b++) begin
            logic [3:0] pend;
            logic [9:0] xs [NREQ];
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                xs[i] = rand_x();
                req_x[i*10 +: 10] = xs[i];
            end
            req_valid = pend;
            while (pend != 4'b0) begin
                int id;
                int d;
                id = rr_pick(pend, ptr_m);
                d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, TIMEOUT - 1));
                serve(id, xs[id], d, exp_q55(xs[id]), int'($urandom_range(0, 3)), 1);
                pend[id] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
